// File: rtl/wb_mux_pkg.sv
// Shared types and constants for the Wishbone slave multiplexer and its
// address decoder.
package wb_mux_pkg;

   localparam int          WB_AW        = 32;
   localparam int          WB_DW        = 32;
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Ceiling log2 for elaboration-time widths; returns 0 for n <= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < n) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_slave_mux_if.sv
// Bus bundle between the MGMT-side Wishbone port and the downstream slaves.
// The mux takes the slave modport; the upstream master and slaves take master.
interface wb_slave_mux_if
   import wb_mux_pkg::*;
#(
   parameter int NUM_SLV = 2
);
   logic                     wbs_cyc_i;
   logic                     wbs_stb_i;
   logic                     wbs_we_i;
   logic [3:0]               wbs_sel_i;
   logic [WB_AW-1:0]         wbs_adr_i;
   logic [WB_DW-1:0]         wbs_dat_i;
   logic                     wbs_ack_o;
   logic [WB_DW-1:0]         wbs_dat_o;
   logic [NUM_SLV-1:0]       slv_cyc_o;
   logic [NUM_SLV-1:0]       slv_stb_o;
   logic                     slv_we_o;
   logic [3:0]               slv_sel_o;
   logic [WB_AW-1:0]         slv_adr_o;
   logic [WB_DW-1:0]         slv_dat_o;
   logic [NUM_SLV-1:0]       slv_ack_i;
   logic [NUM_SLV*WB_DW-1:0] slv_dat_i;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o,
      output slv_cyc_o, slv_stb_o, slv_we_o, slv_sel_o, slv_adr_o, slv_dat_o,
      input  slv_ack_i, slv_dat_i
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o,
      input  slv_cyc_o, slv_stb_o, slv_we_o, slv_sel_o, slv_adr_o, slv_dat_o,
      output slv_ack_i, slv_dat_i
   );
endinterface

// File: rtl/wb_addr_decode.sv
// Base/mask address decoder: one-hot hit vector with lowest-index priority,
// plus a miss bit when no slot matches.
module wb_addr_decode
   import wb_mux_pkg::*;
#(
   parameter int                 N    = 2,
   parameter logic [N*WB_AW-1:0] BASE = '0,
   parameter logic [N*WB_AW-1:0] MASK = '0
) (
   input  logic [WB_AW-1:0] adr_i,
   output logic [N-1:0]     hit_o,
   output logic             miss_o
);

   logic found_s;

   // Priority compare: once a slot matches, higher slots are masked off.
   always_comb begin
      hit_o   = '0;
      found_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found_s && ((adr_i & MASK[i*WB_AW +: WB_AW]) == BASE[i*WB_AW +: WB_AW])) begin
            hit_o[i] = 1'b1;
            found_s  = 1'b1;
         end else begin
            found_s  = found_s;
         end
      end
   end

   assign miss_o = ~found_s;

endmodule

// File: rtl/wb_slave_mux.sv
// One Wishbone slave port fanned out to NUM_SLV slaves by base/mask map, with
// a registered response, an access watchdog and a sticky error capture.
module wb_slave_mux
   import wb_mux_pkg::*;
#(
   parameter int                       NUM_SLV  = 2,
   parameter logic [NUM_SLV*WB_AW-1:0] SLV_BASE = {32'h3800_0000, 32'h3000_0000},
   parameter logic [NUM_SLV*WB_AW-1:0] SLV_MASK = {32'hFF00_0000, 32'hFFFF_0000},
   parameter int                       TIMEOUT  = 255,
   parameter logic [WB_DW-1:0]         ERR_DATA = ERR_DATA_DEF
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   wb_slave_mux_if.slave    bus,
   input  logic             err_clr_i,
   output logic             err_o,
   output logic [WB_AW-1:0] err_adr_o
);

   localparam int              CNT_W    = clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [NUM_SLV-1:0] slot_q;
   logic [NUM_SLV-1:0] cyc_q;
   logic [WB_AW-1:0]   adr_q;
   logic [WB_DW-1:0]   wdat_q;
   logic [WB_DW-1:0]   rdat_q;
   logic [3:0]         sel_q;
   logic               we_q;
   logic               ack_q;
   logic               err_q;
   logic [WB_AW-1:0]   err_adr_q;

   logic [NUM_SLV-1:0] hit_s;
   logic               miss_s;
   logic               req_s;
   logic               slv_ack_s;
   logic               timeout_s;
   logic [WB_DW-1:0]   slv_rdat_s;
   logic               err_evt_s;
   logic [WB_AW-1:0]   err_evt_adr_s;

   wb_addr_decode #(
      .N    (NUM_SLV),
      .BASE (SLV_BASE),
      .MASK (SLV_MASK)
   ) u_decode (
      .adr_i  (bus.wbs_adr_i),
      .hit_o  (hit_s),
      .miss_o (miss_s)
   );

   assign req_s     = bus.wbs_cyc_i & bus.wbs_stb_i;
   assign slv_ack_s = |(bus.slv_ack_i & slot_q);
   assign timeout_s = (cnt_q == CNT_LAST);

   // Select the read data of the latched slot; acks from other slots never reach here.
   always_comb begin
      slv_rdat_s = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         slv_rdat_s = slv_rdat_s | (bus.slv_dat_i[i*WB_DW +: WB_DW] & {WB_DW{slot_q[i]}});
      end
   end

   // Error events: unmapped request in IDLE, or watchdog expiry in BUSY.
   always_comb begin
      err_evt_s     = 1'b0;
      err_evt_adr_s = adr_q;
      case (state_q)
         ST_IDLE: begin
            err_evt_s     = req_s & miss_s;
            err_evt_adr_s = bus.wbs_adr_i;
         end
         ST_BUSY: begin
            err_evt_s     = bus.wbs_cyc_i & ~slv_ack_s & timeout_s;
            err_evt_adr_s = adr_q;
         end
         default: begin
            err_evt_s     = 1'b0;
            err_evt_adr_s = adr_q;
         end
      endcase
   end

   // Transaction FSM with registered slave strobes and master response.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         slot_q  <= '0;
         cyc_q   <= '0;
         adr_q   <= '0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         sel_q   <= 4'b0000;
         we_q    <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         ack_q  <= 1'b0;
         rdat_q <= '0;
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (req_s) begin
                  adr_q  <= bus.wbs_adr_i;
                  sel_q  <= bus.wbs_sel_i;
                  we_q   <= bus.wbs_we_i;
                  slot_q <= hit_s;
                  if (miss_s) begin
                     state_q <= ST_RESP;
                     ack_q   <= 1'b1;
                     rdat_q  <= ERR_DATA;
                  end else begin
                     wdat_q  <= bus.wbs_dat_i;
                     cyc_q   <= hit_s;
                     state_q <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               if (!bus.wbs_cyc_i) begin
                  cyc_q   <= '0;
                  state_q <= ST_IDLE;
               end else if (slv_ack_s) begin
                  cyc_q   <= '0;
                  state_q <= ST_RESP;
                  ack_q   <= 1'b1;
                  rdat_q  <= we_q ? ERR_DATA : slv_rdat_s;
               end else if (timeout_s) begin
                  cyc_q   <= '0;
                  state_q <= ST_RESP;
                  ack_q   <= 1'b1;
                  rdat_q  <= ERR_DATA;
               end else begin
                  cnt_q   <= cnt_q + CNT_W'(1);
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               cyc_q   <= '0;
            end
         endcase
      end
   end

   // Sticky error: the first address is kept until cleared; a clear never hides a new error.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         err_q     <= 1'b0;
         err_adr_q <= '0;
      end else if (err_evt_s && (!err_q || err_clr_i)) begin
         err_q     <= 1'b1;
         err_adr_q <= err_evt_adr_s;
      end else if (err_clr_i && !err_evt_s) begin
         err_q     <= 1'b0;
         err_adr_q <= '0;
      end else begin
         err_q     <= err_q;
         err_adr_q <= err_adr_q;
      end
   end

   // A master abort releases the slave in the same cycle, ahead of the register.
   assign bus.slv_cyc_o = cyc_q & {NUM_SLV{bus.wbs_cyc_i}};
   assign bus.slv_stb_o = cyc_q & {NUM_SLV{bus.wbs_cyc_i}};
   assign bus.slv_we_o  = we_q;
   assign bus.slv_sel_o = sel_q;
   assign bus.slv_adr_o = adr_q;
   assign bus.slv_dat_o = wdat_q;
   assign bus.wbs_ack_o = ack_q;
   assign bus.wbs_dat_o = rdat_q;
   assign err_o         = err_q;
   assign err_adr_o     = err_adr_q;

endmodule

// File: tb/tb_wb_slave_mux.sv
// Scoreboarded bench: two mux instances (2-slot default map, 3-slot overlapping
// map), behavioural slaves with programmable ack delay, directed transfers.
module tb_wb_slave_mux;
   import wb_mux_pkg::*;

   localparam int NEVER = 1000;

   typedef struct {
      logic [31:0] dat;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_a = 1'b0;
   logic        clr_b = 1'b0;
   logic        err_a, err_b;
   logic [31:0] eadr_a, eadr_b;
   int          cycle = 0;
   int          checks = 0;
   int          errors = 0;
   int          dly_a [2];
   int          dly_b [3];
   int          scnt_a [2];
   int          scnt_b [3];
   bit          stray_b [3];
   exp_t        qa [$];
   exp_t        qb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cycle = cycle + 1;

   wb_slave_mux_if #(.NUM_SLV(2)) ia ();
   wb_slave_mux_if #(.NUM_SLV(3)) ib ();

   wb_slave_mux #(
      .NUM_SLV  (2),
      .SLV_BASE ({32'h3800_0000, 32'h3000_0000}),
      .SLV_MASK ({32'hFF00_0000, 32'hFFFF_0000}),
      .TIMEOUT  (8),
      .ERR_DATA (32'hDEAD_BEEF)
   ) u_a (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .bus       (ia.slave),
      .err_clr_i (clr_a),
      .err_o     (err_a),
      .err_adr_o (eadr_a)
   );

   wb_slave_mux #(
      .NUM_SLV  (3),
      .SLV_BASE ({32'h3000_0000, 32'h3800_0000, 32'h3000_0000}),
      .SLV_MASK ({32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_0000}),
      .TIMEOUT  (8),
      .ERR_DATA (32'hDEAD_BEEF)
   ) u_b (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .bus       (ib.slave),
      .err_clr_i (clr_b),
      .err_o     (err_b),
      .err_adr_o (eadr_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] stb_of(input int d);
      return (d == 0) ? {6'd0, ia.slv_stb_o} : {5'd0, ib.slv_stb_o};
   endfunction

   function automatic logic ack_of(input int d);
      return (d == 0) ? ia.wbs_ack_o : ib.wbs_ack_o;
   endfunction

   task automatic drive(input int d, input logic cyc, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input logic we);
      if (d == 0) begin
         ia.wbs_cyc_i = cyc; ia.wbs_stb_i = cyc; ia.wbs_adr_i = adr;
         ia.wbs_dat_i = dat; ia.wbs_sel_i = sel; ia.wbs_we_i = we;
      end else begin
         ib.wbs_cyc_i = cyc; ib.wbs_stb_i = cyc; ib.wbs_adr_i = adr;
         ib.wbs_dat_i = dat; ib.wbs_sel_i = sel; ib.wbs_we_i = we;
      end
   endtask

   // One master access: expected ack data and cycle go to the scoreboard;
   // the broadcast bus is checked on every strobe cycle.
   task automatic xfer(input int d, input string nm, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel, input logic we,
                       input logic [31:0] exp_dat, input int lat,
                       input logic [7:0] exp_stb, input int nstb, input bit clr);
      exp_t e;
      int   nst;
      bit   got;
      nst = 0;
      got = 1'b0;
      @(posedge clk); #1;
      drive(d, 1'b1, adr, dat, sel, we);
      e.dat = exp_dat;
      e.cyc = cycle + lat;
      if (d == 0) qa.push_back(e); else qb.push_back(e);
      if (clr) begin
         clr_a = 1'b1;
         @(posedge clk); #1;
         clr_a = 1'b0;
      end
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (ack_of(d)) begin
            got = 1'b1;
         end else if (stb_of(d) != 8'd0) begin
            nst++;
            chk({nm, " stb"}, {24'd0, stb_of(d)}, {24'd0, exp_stb});
            chk({nm, " adr"}, (d == 0) ? ia.slv_adr_o : ib.slv_adr_o, adr);
            if (we) begin
               chk({nm, " wdat"}, (d == 0) ? ia.slv_dat_o : ib.slv_dat_o, dat);
               chk({nm, " sel"}, {28'd0, (d == 0) ? ia.slv_sel_o : ib.slv_sel_o}, {28'd0, sel});
            end
         end
      end
      chk({nm, " acked"}, 32'(got), 32'd1);
      chk({nm, " strobe cycles"}, 32'(nst), 32'(nstb));
      @(posedge clk); #1;
      drive(d, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
   endtask

   initial begin
      drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      ia.slv_ack_i = '0;
      ib.slv_ack_i = '0;
      ia.slv_dat_i = {32'hCAFE_0001, 32'h1234_5678};
      ib.slv_dat_i = {32'h0000_00B2, 32'h0000_00B1, 32'h0000_00B0};
      for (int s = 0; s < 2; s++) begin dly_a[s] = 0; scnt_a[s] = 0; end
      for (int s = 0; s < 3; s++) begin dly_b[s] = 0; scnt_b[s] = 0; stray_b[s] = 1'b0; end

      fork
         // Behavioural slaves: ack in strobe cycle dly+1; stray acks on B ignore the strobe.
         forever begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
               if (ia.slv_stb_o[s]) begin
                  scnt_a[s]++;
                  ia.slv_ack_i[s] = (scnt_a[s] == dly_a[s] + 1);
               end else begin
                  scnt_a[s] = 0;
                  ia.slv_ack_i[s] = 1'b0;
               end
            end
            for (int s = 0; s < 3; s++) begin
               if (ib.slv_stb_o[s]) begin
                  scnt_b[s]++;
                  ib.slv_ack_i[s] = (scnt_b[s] == dly_b[s] + 1) || stray_b[s];
               end else begin
                  scnt_b[s] = 0;
                  ib.slv_ack_i[s] = stray_b[s];
               end
            end
         end
         // Scoreboard monitor A
         forever begin
            @(negedge clk);
            if (ia.wbs_ack_o) begin
               checks++;
               if (qa.size() == 0) begin
                  errors++;
                  $display("FAIL A unexpected ack: got ack with dat %h, expected none", ia.wbs_dat_o);
               end else begin
                  exp_t e;
                  e = qa.pop_front();
                  chk("A rdata", ia.wbs_dat_o, e.dat);
                  chk("A ack cycle", 32'(cycle), 32'(e.cyc));
               end
            end else begin
               chk("A dat idle", ia.wbs_dat_o, 32'h0);
            end
         end
         // Scoreboard monitor B
         forever begin
            @(negedge clk);
            if (ib.wbs_ack_o) begin
               checks++;
               if (qb.size() == 0) begin
                  errors++;
                  $display("FAIL B unexpected ack: got ack with dat %h, expected none", ib.wbs_dat_o);
               end else begin
                  exp_t e;
                  e = qb.pop_front();
                  chk("B rdata", ib.wbs_dat_o, e.dat);
                  chk("B ack cycle", 32'(cycle), 32'(e.cyc));
               end
            end else begin
               chk("B dat idle", ib.wbs_dat_o, 32'h0);
            end
         end
      join_none

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst ack", {31'd0, ia.wbs_ack_o}, 32'd0);
      chk("rst stb", {30'd0, ia.slv_stb_o}, 32'd0);
      chk("rst cyc", {30'd0, ia.slv_cyc_o}, 32'd0);
      chk("rst adr", ia.slv_adr_o, 32'h0);
      chk("rst err", {31'd0, err_a}, 32'd0);
      chk("rst err_adr", eadr_a, 32'h0);
      rst = 1'b0;

      // Read, slave 0 acks on its first strobe cycle
      dly_a[0] = 0;
      xfer(0, "read", 32'h3000_0004, 32'h0, 4'hF, 1'b0, 32'h1234_5678, 2, 8'h01, 1, 1'b0);
      chk("read err", {31'd0, err_a}, 32'd0);

      // Write to slave 1, ack after 3 cycles; writes answer ERR_DATA
      dly_a[1] = 3;
      xfer(0, "write", 32'h3800_0010, 32'hA5A5_A5A5, 4'b0011, 1'b1, 32'hDEAD_BEEF, 5, 8'h02, 4, 1'b0);
      chk("write err", {31'd0, err_a}, 32'd0);

      // Unmapped
      xfer(0, "unmapped", 32'h2000_0000, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 1, 8'h00, 0, 1'b0);
      chk("unmapped err", {31'd0, err_a}, 32'd1);
      chk("unmapped err_adr", eadr_a, 32'h2000_0000);

      @(posedge clk); #1; clr_a = 1'b1;
      @(posedge clk); #1; clr_a = 1'b0;
      chk("clr1 err", {31'd0, err_a}, 32'd0);
      chk("clr1 err_adr", eadr_a, 32'h0);

      // Watchdog: 8 strobe cycles then error response
      dly_a[0] = NEVER;
      xfer(0, "timeout", 32'h3000_0100, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 9, 8'h01, 8, 1'b0);
      chk("timeout err", {31'd0, err_a}, 32'd1);
      chk("timeout err_adr", eadr_a, 32'h3000_0100);
      xfer(0, "second err", 32'h4000_0000, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 1, 8'h00, 0, 1'b0);
      chk("second err_adr kept", eadr_a, 32'h3000_0100);

      @(posedge clk); #1; clr_a = 1'b1;
      @(posedge clk); #1; clr_a = 1'b0;
      chk("clr2 err", {31'd0, err_a}, 32'd0);
      chk("clr2 err_adr", eadr_a, 32'h0);

      // Clear coinciding with a new error: the new error is recorded
      xfer(0, "err pre", 32'h1000_0000, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 1, 8'h00, 0, 1'b0);
      xfer(0, "err+clr", 32'h5000_0000, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 1, 8'h00, 0, 1'b1);
      chk("err+clr err", {31'd0, err_a}, 32'd1);
      chk("err+clr err_adr", eadr_a, 32'h5000_0000);

      // Master abort in BUSY
      dly_a[1] = NEVER;
      @(posedge clk); #1;
      drive(0, 1'b1, 32'h3800_0000, 32'h0, 4'hF, 1'b0);
      repeat (3) @(negedge clk);
      chk("abort stb busy", {30'd0, ia.slv_stb_o}, 32'd2);
      #1;
      drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      #1;
      chk("abort stb drop", {30'd0, ia.slv_stb_o}, 32'd0);
      repeat (3) @(negedge clk);
      chk("abort err kept", {31'd0, err_a}, 32'd1);
      chk("abort err_adr kept", eadr_a, 32'h5000_0000);
      dly_a[1] = 1;
      xfer(0, "after abort", 32'h3800_0020, 32'h0, 4'hF, 1'b0, 32'hCAFE_0001, 3, 8'h02, 2, 1'b0);

      // Overlapping map on B: slot 0 wins, stray slot-2 acks ignored
      dly_b[0] = 2;
      stray_b[2] = 1'b1;
      xfer(1, "overlap", 32'h3000_0000, 32'h0, 4'hF, 1'b0, 32'h0000_00B0, 4, 8'h01, 3, 1'b0);
      stray_b[2] = 1'b0;
      dly_b[2] = 0;
      xfer(1, "slot2", 32'h30AB_0000, 32'h0, 4'hF, 1'b0, 32'h0000_00B2, 2, 8'h04, 1, 1'b0);
      chk("B err", {31'd0, err_b}, 32'd0);

      // Asynchronous reset mid-BUSY
      dly_a[0] = NEVER;
      @(posedge clk); #1;
      drive(0, 1'b1, 32'h3000_0000, 32'h0, 4'hF, 1'b0);
      repeat (2) @(negedge clk);
      chk("pre-rst stb", {30'd0, ia.slv_stb_o}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst stb", {30'd0, ia.slv_stb_o}, 32'd0);
      chk("async rst cyc", {30'd0, ia.slv_cyc_o}, 32'd0);
      chk("async rst err", {31'd0, err_a}, 32'd0);
      chk("async rst err_adr", eadr_a, 32'h0);
      chk("async rst slv_adr", ia.slv_adr_o, 32'h0);
      @(posedge clk); #1;
      drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      rst = 1'b0;
      dly_a[0] = 0;
      xfer(0, "after rst", 32'h3000_0008, 32'h0, 4'hF, 1'b0, 32'h1234_5678, 2, 8'h01, 1, 1'b0);

      repeat (4) @(negedge clk);
      chk("A acks outstanding", 32'(qa.size()), 32'd0);
      chk("B acks outstanding", 32'(qb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
